// File: rtl/kamus_pkg.sv
// kamus_pkg: shared operation codes, memory-stage types and decode helpers
package kamus_pkg;
    typedef enum logic [5:0] {
        OP_ADD = 6'h00,
        OP_SUB = 6'h01,
        OP_AND = 6'h02,
        OP_OR  = 6'h03,
        OP_XOR = 6'h04,
        OP_LB  = 6'h10,
        OP_LH  = 6'h11,
        OP_LW  = 6'h12,
        OP_LBU = 6'h14,
        OP_LHU = 6'h15,
        OP_SB  = 6'h18,
        OP_SH  = 6'h19,
        OP_SW  = 6'h1a
    } operation_t;
    typedef enum logic [1:0] {MEM_BYTE, MEM_HALF, MEM_WORD} mem_size_e;
    typedef enum logic [1:0] {MS_IDLE, MS_REQ, MS_WAIT} mem_state_e;
    typedef struct packed {
        operation_t  op;
        logic [31:0] ex;
        logic [31:0] wdata;
        logic [31:0] npc;
        logic [4:0]  rd;
        logic [1:0]  sel;
        logic        rf_we;
        logic        we;
        logic        kill;
    } mem_req_t;
    function automatic logic is_load(operation_t op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    endfunction
    function automatic logic is_store(operation_t op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction
    function automatic mem_size_e op_size(operation_t op);
        return (op inside {OP_LB, OP_LBU, OP_SB}) ? MEM_BYTE :
               (op inside {OP_LH, OP_LHU, OP_SH}) ? MEM_HALF : MEM_WORD;
    endfunction
    function automatic logic op_unsigned(operation_t op);
        return op inside {OP_LBU, OP_LHU};
    endfunction
endpackage

// File: rtl/kamus_lsu_align.sv
// kamus_lsu_align: byte enables, store lane replication and load extraction/extension
module kamus_lsu_align
    import kamus_pkg::*;
(
    input  mem_size_e   size,
    input  logic        uns,
    input  logic [1:0]  a,
    input  logic [31:0] rs2,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ldata
);
    logic [31:0] sh;
    always_comb begin
        sh    = rdata >> {a, 3'b000};
        be    = size == MEM_BYTE ? 4'b0001 << a : size == MEM_HALF ? 4'b0011 << a : 4'b1111;
        wdata = size == MEM_BYTE ? {4{rs2[7:0]}} : size == MEM_HALF ? {2{rs2[15:0]}} : rs2;
        ldata = size == MEM_BYTE ? {{24{~uns & sh[7]}}, sh[7:0]} :
                size == MEM_HALF ? {{16{~uns & sh[15]}}, sh[15:0]} : rdata;
    end
endmodule

// File: rtl/kamus_mem_stage.sv
// kamus_mem_stage: L1D access stage with req/gnt/rvalid handshake feeding the MEM/WB register
module kamus_mem_stage
    import kamus_pkg::*;
#(
    parameter bit MISALIGN_TRAP = 1'b1,
    parameter int OP_W          = 6
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic            flush_i,
    input  logic [OP_W-1:0] operation_i,
    input  logic [31:0]     ex_i,
    input  logic [31:0]     rs2_data_i,
    input  logic [4:0]      rd_addr_i,
    input  logic [31:0]     next_pc_i,
    input  logic            l1d_wr_en_i,
    input  logic            regfile_wr_en_i,
    input  logic [1:0]      wb_mux_sel_i,
    output logic            l1d_req_o,
    output logic            l1d_we_o,
    output logic [31:0]     l1d_addr_o,
    output logic [3:0]      l1d_be_o,
    output logic [31:0]     l1d_wdata_o,
    input  logic            l1d_gnt_i,
    input  logic            l1d_rvalid_i,
    input  logic [31:0]     l1d_rdata_i,
    output logic            wb_valid_o,
    output logic [4:0]      rd_addr_o,
    output logic            regfile_wr_en_o,
    output logic [1:0]      wb_mux_sel_o,
    output logic [31:0]     ex_o,
    output logic [31:0]     mem_data_o,
    output logic [31:0]     next_pc_o,
    output logic            misaligned_o
);
    mem_state_e  state, nxt;
    mem_req_t    in_req, q, cur;
    mem_size_e   size;
    logic        idle, accept, mem, mis_raw, trap, done, kill_now;
    logic [1:0]  a;
    logic [31:0] ldata;
    // In IDLE the live inputs drive the bus; afterwards the captured copy holds it stable
    always_comb begin
        in_req   = '{op: operation_t'(operation_i), ex: ex_i, wdata: rs2_data_i, npc: next_pc_i,
                     rd: rd_addr_i, sel: wb_mux_sel_i, rf_we: regfile_wr_en_i,
                     we: l1d_wr_en_i && is_store(operation_t'(operation_i)), kill: 1'b0};
        idle     = state == MS_IDLE;
        cur      = idle ? in_req : q;
        size     = op_size(cur.op);
        mem      = is_load(cur.op) || cur.we;
        mis_raw  = (size == MEM_HALF && cur.ex[0]) || (size == MEM_WORD && cur.ex[1:0] != 2'b00);
        trap     = MISALIGN_TRAP && mem && mis_raw;
        a        = MISALIGN_TRAP ? cur.ex[1:0] : size == MEM_WORD ? 2'b00 :
                   size == MEM_HALF ? {cur.ex[1], 1'b0} : cur.ex[1:0];
        accept   = idle && valid_i && !flush_i;
        kill_now = !idle && (q.kill || flush_i);
        ready_o  = idle;
        l1d_req_o   = (accept && mem && !trap) || state == MS_REQ;
        l1d_we_o    = l1d_req_o && cur.we;
        l1d_addr_o  = {cur.ex[31:2], 2'b00};
        done     = (accept && (!mem || trap || (cur.we && l1d_gnt_i))) ||
                   (state == MS_REQ && l1d_gnt_i && cur.we) ||
                   (state == MS_WAIT && l1d_rvalid_i);
        nxt      = idle ? ((accept && mem && !trap) ?
                           (l1d_gnt_i ? (cur.we ? MS_IDLE : MS_WAIT) : MS_REQ) : MS_IDLE) :
                   state == MS_REQ ? (l1d_gnt_i ? (cur.we ? MS_IDLE : MS_WAIT) : MS_REQ) :
                   (l1d_rvalid_i ? MS_IDLE : MS_WAIT);
    end
    kamus_lsu_align u_align (
        .size  (size),
        .uns   (op_unsigned(cur.op)),
        .a     (a),
        .rs2   (cur.wdata),
        .rdata (l1d_rdata_i),
        .be    (l1d_be_o),
        .wdata (l1d_wdata_o),
        .ldata (ldata)
    );
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state           <= MS_IDLE;
            q               <= '0;
            wb_valid_o      <= 1'b0;
            misaligned_o    <= 1'b0;
            regfile_wr_en_o <= 1'b0;
            rd_addr_o       <= '0;
            wb_mux_sel_o    <= '0;
            ex_o            <= '0;
            next_pc_o       <= '0;
            mem_data_o      <= '0;
        end else begin
            state           <= nxt;
            wb_valid_o      <= done;
            misaligned_o    <= done && trap;
            regfile_wr_en_o <= done && cur.rf_we && !trap && !kill_now;
            if (accept) q <= in_req;
            else if (!idle && flush_i) q.kill <= 1'b1;
            if (done) begin
                rd_addr_o    <= cur.rd;
                wb_mux_sel_o <= cur.sel;
                ex_o         <= cur.ex;
                next_pc_o    <= cur.npc;
                if (state == MS_WAIT) mem_data_o <= ldata;
            end
        end
    end
endmodule

// File: tb/tb_kamus_mem_stage.sv
// tb_kamus_mem_stage: directed vectors against hand-computed results for kamus_mem_stage
module tb_kamus_mem_stage;
    import kamus_pkg::*;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        valid = 1'b0, flush = 1'b0, wr_en = 1'b0, rf_we = 1'b0;
    logic [5:0]  op = OP_ADD;
    logic [31:0] ex = '0, rs2 = '0, npc = '0, rdata = '0;
    logic [4:0]  rd = '0;
    logic [1:0]  sel = '0;
    logic        gnt = 1'b0, rvalid = 1'b0;
    logic        ready, req, we, wb_valid, rf_we_o, mis;
    logic [31:0] addr, wdata, ex_o, mem_data, npc_o;
    logic [3:0]  be;
    logic [4:0]  rd_o;
    logic [1:0]  sel_o;
    int vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    kamus_mem_stage dut (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .ready_o(ready), .flush_i(flush),
        .operation_i(op), .ex_i(ex), .rs2_data_i(rs2), .rd_addr_i(rd), .next_pc_i(npc),
        .l1d_wr_en_i(wr_en), .regfile_wr_en_i(rf_we), .wb_mux_sel_i(sel),
        .l1d_req_o(req), .l1d_we_o(we), .l1d_addr_o(addr), .l1d_be_o(be), .l1d_wdata_o(wdata),
        .l1d_gnt_i(gnt), .l1d_rvalid_i(rvalid), .l1d_rdata_i(rdata),
        .wb_valid_o(wb_valid), .rd_addr_o(rd_o), .regfile_wr_en_o(rf_we_o),
        .wb_mux_sel_o(sel_o), .ex_o(ex_o), .mem_data_o(mem_data), .next_pc_o(npc_o),
        .misaligned_o(mis)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] o, input logic [31:0] e, input logic [31:0] s,
                         input logic [4:0] r, input logic w, input logic rf);
        valid = 1'b1; op = o; ex = e; rs2 = s; rd = r; wr_en = w; rf_we = rf; npc = e + 32'd4;
    endtask

    initial begin
        step(); step();
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_ex_o", ex_o, 32'h0);
        chk("rst_req", 32'(req), 32'd0);
        rst_n = 1'b1;
        step();
        chk("rel_ready", 32'(ready), 32'd1);

        // ADD: one-cycle pass-through
        issue(OP_ADD, 32'h1234, 32'h0, 5'd5, 1'b0, 1'b1);
        #1 chk("add_req", 32'(req), 32'd0);
        step();
        valid = 1'b0;
        chk("add_wb_valid", 32'(wb_valid), 32'd1);
        chk("add_ex_o", ex_o, 32'h1234);
        chk("add_rd", 32'(rd_o), 32'd5);
        chk("add_rf_we", 32'(rf_we_o), 32'd1);
        chk("add_npc", npc_o, 32'h1238);
        chk("add_ready", 32'(ready), 32'd1);
        step();
        chk("idle_wb_valid", 32'(wb_valid), 32'd0);
        chk("idle_rf_we", 32'(rf_we_o), 32'd0);
        chk("idle_ex_hold", ex_o, 32'h1234);

        // SB granted same cycle
        issue(OP_SB, 32'h1003, 32'hAABBCCDD, 5'd0, 1'b1, 1'b0);
        gnt = 1'b1;
        #1;
        chk("sb_req", 32'(req), 32'd1);
        chk("sb_we", 32'(we), 32'd1);
        chk("sb_addr", addr, 32'h1000);
        chk("sb_be", 32'(be), 32'b1000);
        chk("sb_wdata", wdata, 32'hDDDDDDDD);
        step();
        valid = 1'b0; gnt = 1'b0;
        chk("sb_wb_valid", 32'(wb_valid), 32'd1);
        chk("sb_ready", 32'(ready), 32'd1);

        // LB with gnt delayed two cycles, rvalid three cycles after gnt
        issue(OP_LB, 32'h2002, 32'h0, 5'd7, 1'b0, 1'b1);
        #1;
        chk("lb_req0", 32'(req), 32'd1);
        chk("lb_be", 32'(be), 32'b0100);
        step();
        valid = 1'b0; ex = 32'hDEADBEEF;
        #1;
        chk("lb_ready_req", 32'(ready), 32'd0);
        chk("lb_req1", 32'(req), 32'd1);
        chk("lb_addr_hold", addr, 32'h2000);
        chk("lb_be_hold", 32'(be), 32'b0100);
        step();
        gnt = 1'b1;
        #1 chk("lb_req2", 32'(req), 32'd1);
        step();
        gnt = 1'b0;
        chk("lb_wait_req", 32'(req), 32'd0);
        chk("lb_wait_ready", 32'(ready), 32'd0);
        step();
        step();
        rvalid = 1'b1; rdata = 32'h00800000;
        chk("lb_ready_rv", 32'(ready), 32'd0);
        step();
        rvalid = 1'b0;
        chk("lb_wb_valid", 32'(wb_valid), 32'd1);
        chk("lb_data", mem_data, 32'hFFFFFF80);
        chk("lb_rf_we", 32'(rf_we_o), 32'd1);
        chk("lb_rd", 32'(rd_o), 32'd7);
        chk("lb_ex_o", ex_o, 32'h2002);
        chk("lb_ready_done", 32'(ready), 32'd1);

        // LHU then LH at the upper halfword, LBU byte 1, aligned LW
        issue(OP_LHU, 32'h2002, 32'h0, 5'd8, 1'b0, 1'b1);
        gnt = 1'b1;
        #1 chk("lhu_be", 32'(be), 32'b1100);
        step();
        valid = 1'b0; gnt = 1'b0; rvalid = 1'b1; rdata = 32'h80010000;
        step();
        rvalid = 1'b0;
        chk("lhu_data", mem_data, 32'h00008001);
        issue(OP_LH, 32'h2002, 32'h0, 5'd8, 1'b0, 1'b1);
        gnt = 1'b1;
        step();
        valid = 1'b0; gnt = 1'b0; rvalid = 1'b1; rdata = 32'h80010000;
        step();
        rvalid = 1'b0;
        chk("lh_data", mem_data, 32'hFFFF8001);
        issue(OP_LBU, 32'h1001, 32'h0, 5'd9, 1'b0, 1'b1);
        gnt = 1'b1;
        #1 chk("lbu_be", 32'(be), 32'b0010);
        step();
        valid = 1'b0; gnt = 1'b0; rvalid = 1'b1; rdata = 32'h0000F000;
        step();
        rvalid = 1'b0;
        chk("lbu_data", mem_data, 32'h000000F0);
        issue(OP_LW, 32'h3000, 32'h0, 5'd10, 1'b0, 1'b1);
        gnt = 1'b1;
        #1 chk("lw_be", 32'(be), 32'b1111);
        step();
        valid = 1'b0; gnt = 1'b0; rvalid = 1'b1; rdata = 32'hCAFEBABE;
        step();
        rvalid = 1'b0;
        chk("lw_data", mem_data, 32'hCAFEBABE);

        // SH upper half
        issue(OP_SH, 32'h0002, 32'h1234ABCD, 5'd0, 1'b1, 1'b0);
        gnt = 1'b1;
        #1;
        chk("sh_be", 32'(be), 32'b1100);
        chk("sh_wdata", wdata, 32'hABCDABCD);
        step();
        valid = 1'b0; gnt = 1'b0;

        // Misaligned LW traps without a request
        issue(OP_LW, 32'h3002, 32'h0, 5'd11, 1'b0, 1'b1);
        gnt = 1'b1;
        #1 chk("mis_req", 32'(req), 32'd0);
        step();
        valid = 1'b0; gnt = 1'b0;
        chk("mis_wb_valid", 32'(wb_valid), 32'd1);
        chk("mis_flag", 32'(mis), 32'd1);
        chk("mis_rf_we", 32'(rf_we_o), 32'd0);
        chk("mis_ready", 32'(ready), 32'd1);
        step();
        chk("mis_pulse", 32'(mis), 32'd0);
        issue(OP_SH, 32'h3003, 32'h0, 5'd0, 1'b1, 1'b0);
        #1 chk("mis_sh_req", 32'(req), 32'd0);
        step();
        valid = 1'b0;
        chk("mis_sh_flag", 32'(mis), 32'd1);

        // Flush during WAIT: bus completes, no register write
        issue(OP_LW, 32'h4000, 32'h0, 5'd12, 1'b0, 1'b1);
        gnt = 1'b1;
        step();
        valid = 1'b0; gnt = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0; rvalid = 1'b1; rdata = 32'h11223344;
        step();
        rvalid = 1'b0;
        chk("fl_wb_valid", 32'(wb_valid), 32'd1);
        chk("fl_rf_we", 32'(rf_we_o), 32'd0);
        chk("fl_data", mem_data, 32'h11223344);

        // Flush in IDLE discards the input
        issue(OP_ADD, 32'h55, 32'h0, 5'd13, 1'b0, 1'b1);
        flush = 1'b1;
        step();
        valid = 1'b0; flush = 1'b0;
        chk("fli_wb_valid", 32'(wb_valid), 32'd0);
        chk("fli_ex_hold", ex_o, 32'h4000);

        // Reset while in WAIT drops the transaction; late rvalid ignored
        issue(OP_LW, 32'h5000, 32'h0, 5'd14, 1'b0, 1'b1);
        gnt = 1'b1;
        step();
        valid = 1'b0; gnt = 1'b0; rst_n = 1'b0;
        step();
        chk("rw_ready", 32'(ready), 32'd1);
        chk("rw_ex_o", ex_o, 32'h0);
        chk("rw_mem_data", mem_data, 32'h0);
        chk("rw_rd", 32'(rd_o), 32'd0);
        rst_n = 1'b1; rvalid = 1'b1; rdata = 32'h99999999;
        step();
        rvalid = 1'b0;
        chk("rw_stray_valid", 32'(wb_valid), 32'd0);
        chk("rw_stray_data", mem_data, 32'h0);
        chk("rw_stray_ready", 32'(ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
